fir_mac_ctrl: RTL and testbench

- Sequencer and multiply-accumulate datapath for the FIR filter.
- Drives two single-port RAM instances: a sample RAM used as a circular delay line, and a coefficient RAM. Both RAMs have a combinational read and a synchronous write on the shared address.
- Accepts one input sample per handshake, writes it into the delay line, and accumulates TAPS products.
- Emits one rounded, saturated output sample per input through a valid/ready handshake.

---
 rtl/fir_mac_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_fir_mac_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_ctrl.sv
// FIR filter sequencer and multiply-accumulate datapath.
// Keeps a circular delay line in an external sample RAM and reads its
// coefficients from an external coefficient RAM. Both RAMs read
// combinationally and write synchronously on a shared address.
// Each accepted sample produces one rounded, saturated output through a
// valid/ready handshake.
module fir_mac_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TAPS       = 32,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH,
    parameter int unsigned OUT_SHIFT  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic                  clr,
    input  logic                  coef_wr,
    input  logic [ADDR_WIDTH-1:0] coef_addr,
    input  logic [DATA_WIDTH-1:0] coef_data,
    output logic                  coef_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] smp_adres,
    output logic [DATA_WIDTH-1:0] smp_data,
    output logic                  smp_wr,
    input  logic [DATA_WIDTH-1:0] smp_q,
    output logic [ADDR_WIDTH-1:0] cf_adres,
    output logic [DATA_WIDTH-1:0] cf_data,
    output logic                  cf_wr,
    input  logic [DATA_WIDTH-1:0] cf_q
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WRITE,
        ST_MAC,
        ST_ROUND,
        ST_OUT
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TAPS - 1);
    localparam int unsigned           PROD_W   = 2 * DATA_WIDTH;
    localparam int unsigned           EXT_W    = ACC_WIDTH - PROD_W;
    localparam logic [DATA_WIDTH-1:0] OUT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]        rptr_q, rptr_d;
    logic [ADDR_WIDTH-1:0]        k_q, k_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0]        sample_q, sample_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;

    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH:0]    rnd_bias;
    logic signed [ACC_WIDTH:0]    rnd_sum;
    logic signed [ACC_WIDTH:0]    rnd_shift;
    logic                         rnd_fits;
    logic [DATA_WIDTH-1:0]        sat_val;

    // Product, rounding and saturation arithmetic shared by MAC and ROUND
    always_comb begin
        prod      = $signed(smp_q) * $signed(cf_q);
        prod_ext  = {{EXT_W{prod[PROD_W-1]}}, prod};
        rnd_bias  = '0;
        rnd_bias[OUT_SHIFT-1] = 1'b1;
        // One guard bit so the rounding bias can never wrap the sum
        rnd_sum   = {acc_q[ACC_WIDTH-1], acc_q} + rnd_bias;
        rnd_shift = rnd_sum >>> OUT_SHIFT;
        // Result fits the output width when all bits above it match its sign bit
        rnd_fits  = (rnd_shift[ACC_WIDTH:DATA_WIDTH-1] == '0) ||
                    (rnd_shift[ACC_WIDTH:DATA_WIDTH-1] == '1);
        if (rnd_fits) begin
            sat_val = rnd_shift[DATA_WIDTH-1:0];
        end else if (rnd_shift[ACC_WIDTH]) begin
            sat_val = OUT_MIN;
        end else begin
            sat_val = OUT_MAX;
        end
    end

    // State register and datapath flops; reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update per state
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        k_d         = k_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    k_d     = '0;
                    state_d = ST_CLEAR;
                end else if (in_valid) begin
                    sample_d = in_sample;
                    state_d  = ST_WRITE;
                end
            end

            ST_CLEAR: begin
                if (k_q == LAST_IDX) begin
                    k_d     = '0;
                    wptr_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            ST_WRITE: begin
                acc_d   = '0;
                rptr_d  = wptr_q;
                k_d     = '0;
                state_d = ST_MAC;
            end

            ST_MAC: begin
                acc_d  = acc_q + prod_ext;
                rptr_d = (rptr_q == '0) ? LAST_IDX : rptr_q - 1'b1;
                if (k_q == LAST_IDX) begin
                    k_d     = '0;
                    state_d = ST_ROUND;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            ST_ROUND: begin
                out_data_d  = sat_val;
                out_valid_d = 1'b1;
                wptr_d      = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
                state_d     = ST_OUT;
            end

            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and RAM port drive per state
    always_comb begin
        in_ready   = 1'b0;
        coef_ready = 1'b0;
        busy       = (state_q != ST_IDLE);
        smp_adres  = wptr_q;
        smp_data   = sample_q;
        smp_wr     = 1'b0;
        cf_adres   = k_q;
        cf_data    = coef_data;
        cf_wr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready   = !clr;
                coef_ready = 1'b1;
                cf_adres   = coef_addr;
                cf_wr      = coef_wr;
            end
            ST_CLEAR: begin
                smp_adres = k_q;
                smp_data  = '0;
                smp_wr    = 1'b1;
            end
            ST_WRITE: begin
                smp_wr = 1'b1;
            end
            ST_MAC: begin
                smp_adres = rptr_q;
            end
            default: begin
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench for fir_mac_ctrl with behavioural RAMs and a
// sample-history filter model checked every cycle.
module tb_fir_mac_ctrl;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 16;
    localparam int unsigned TAPS = 32;
    localparam int unsigned OS   = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_sample;
    logic          clr;
    logic          coef_wr;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_data;
    logic          coef_ready;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [AW-1:0] smp_adres, cf_adres;
    logic [DW-1:0] smp_data, smp_q, cf_data, cf_q;
    logic          smp_wr, cf_wr;

    always #5 clk = ~clk;

    fir_mac_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TAPS(TAPS),
        .ACC_WIDTH(2 * DW + AW),
        .OUT_SHIFT(OS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .clr(clr),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(coef_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy),
        .smp_adres(smp_adres), .smp_data(smp_data), .smp_wr(smp_wr), .smp_q(smp_q),
        .cf_adres(cf_adres), .cf_data(cf_data), .cf_wr(cf_wr), .cf_q(cf_q)
    );

    // Single-port RAMs: combinational read, synchronous write
    logic [DW-1:0] smp_mem [0:(1<<AW)-1];
    logic [DW-1:0] cf_mem  [0:(1<<AW)-1];
    assign smp_q = smp_mem[smp_adres];
    assign cf_q  = cf_mem[cf_adres];
    always @(posedge clk) begin
        if (smp_wr) smp_mem[smp_adres] <= smp_data;
        if (cf_wr)  cf_mem[cf_adres]   <= cf_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_CLEAR, M_PROC} mmode_e;
    mmode_e m_mode = M_IDLE;
    int     m_cnt  = 0;
    int     m_y    = 0;
    logic   m_ov;
    int     h [TAPS];
    int     hist [$];   // hist[0] = newest sample since last clear

    function automatic int model_y();
        longint acc;
        acc = 0;
        for (int k = 0; k < hist.size(); k++)
            acc += longint'(h[k]) * longint'(hist[k]);
        acc = (acc + (longint'(1) <<< (OS - 1))) >>> OS;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    // Compare DUT against the model every cycle, then advance the model
    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            check("rst_out_valid", longint'(out_valid), 0);
            check("rst_busy", longint'(busy), 0);
        end else begin
            m_ov = (m_mode == M_PROC) && (m_cnt >= TAPS + 2);
            check("busy", longint'(busy), longint'(m_mode != M_IDLE));
            check("in_ready", longint'(in_ready), longint'((m_mode == M_IDLE) && !clr));
            check("coef_ready", longint'(coef_ready), longint'(m_mode == M_IDLE));
            check("out_valid", longint'(out_valid), longint'(m_ov));
            if (m_ov) check("out_data", longint'($signed(out_data)), longint'(m_y));
            case (m_mode)
                M_IDLE: begin
                    if (coef_wr) h[coef_addr] = int'($signed(coef_data));
                    if (clr) begin
                        hist.delete();
                        m_mode = M_CLEAR;
                        m_cnt  = TAPS;
                    end else if (in_valid) begin
                        hist.push_front(int'($signed(in_sample)));
                        if (hist.size() > TAPS) void'(hist.pop_back());
                        m_y    = model_y();
                        m_mode = M_PROC;
                        m_cnt  = 0;
                    end
                end
                M_CLEAR: begin
                    m_cnt--;
                    if (m_cnt == 0) m_mode = M_IDLE;
                end
                M_PROC: begin
                    if (m_ov && out_ready) m_mode = M_IDLE;
                    else m_cnt++;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int addr, input logic [DW-1:0] val);
        coef_wr   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = val;
        tick();
        coef_wr   = 1'b0;
    endtask

    task automatic set_all_coefs(input logic [DW-1:0] val);
        for (int i = 0; i < TAPS; i++) wr_coef(i, val);
    endtask

    task automatic do_clr(output int n);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeout("clr_done");
    endtask

    task automatic accept(input logic [DW-1:0] s);
        int n;
        n = 0;
        in_sample = s;
        in_valid  = 1'b1;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) timeout("accept");
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; lat counts edges from the accepting edge
    task automatic wait_out(output logic signed [DW-1:0] y, output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout("out_valid");
        lat = n;
        y   = out_data;
    endtask

    task automatic send(input logic [DW-1:0] s, output logic signed [DW-1:0] y, output int lat);
        accept(s);
        wait_out(y, lat);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [DW-1:0] y;
        int lat;
        int n;
        logic [DW-1:0] t2_in  [5];
        int            t2_exp [5];
        t2_in  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        t2_exp = '{0, 0, 0, 16384, 0};

        in_valid = 1'b0; in_sample = '0; clr = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_data", longint'(out_data), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_smp_wr", longint'(smp_wr), 0);
        check("reset_cf_wr", longint'(cf_wr), 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", longint'(in_ready), 1);

        // Single tap at 0.5: 1000 -> 500, latency TAPS+2
        set_all_coefs('0);
        wr_coef(0, 16'h4000);
        do_clr(n);
        check("clr_busy_cycles", n, 32);
        send(16'd1000, y, lat);
        check("t1_out", longint'(y), 500);
        check("t1_latency", lat, 34);

        // Pure delay of 3 with gain ~1
        wr_coef(0, 16'h0000);
        wr_coef(3, 16'h7FFF);
        do_clr(n);
        for (int i = 0; i < 5; i++) begin
            send(t2_in[i], y, lat);
            check($sformatf("t2_out%0d", i), longint'(y), t2_exp[i]);
        end

        // Positive and negative saturation
        set_all_coefs(16'h7FFF);
        do_clr(n);
        send(16'h7FFF, y, lat);
        send(16'h7FFF, y, lat);
        check("sat_pos", longint'(y), 32767);
        do_clr(n);
        send(16'h8000, y, lat);
        send(16'h8000, y, lat);
        check("sat_neg", longint'(y), -32768);

        // Last tap only: pointer wrap-around over 40 samples
        set_all_coefs('0);
        wr_coef(31, 16'h4000);
        do_clr(n);
        for (int i = 1; i <= 40; i++) begin
            send(DW'(64 * i), y, lat);
            check($sformatf("wrap_n%0d", i), longint'(y), (i <= 31) ? 0 : 32 * (i - 31));
        end

        // Backpressure: sample 41 -> x[10]/2 = 320; sample 42 -> x[11]/2 = 352
        out_ready = 1'b0;
        accept(16'd100);
        wait_out(y, lat);
        in_sample = 16'd200;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_out_data", longint'($signed(out_data)), 320);
            check("bp_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        check("bp_in_ready_still_low", longint'(in_ready), 0);
        tick();
        check("bp_in_ready_after", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", longint'(busy), 1);
        wait_out(y, lat);
        check("bp_second_out", longint'(y), 352);
        check("bp_second_latency", lat, 34);
        tick();

        // Coefficient write attempted mid-MAC: sample 43 -> x[12]/2 = 384
        accept(16'd300);
        repeat (3) tick();
        coef_wr   = 1'b1;
        coef_addr = '0;
        coef_data = 16'h1234;
        repeat (3) tick();
        coef_wr = 1'b0;
        wait_out(y, lat);
        check("mac_coef_out", longint'(y), 384);
        tick();
        check("cf0_unchanged", longint'(cf_mem[0]), 0);

        // Asynchronous reset in the middle of MAC
        accept(16'd400);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", longint'(busy), 0);
        check("async_rst_out_valid", longint'(out_valid), 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("post_rst_in_ready", longint'(in_ready), 1);
        tick();
        check("post_rst_in_ready2", longint'(in_ready), 1);
        wr_coef(0, 16'h4000);
        do_clr(n);
        send(16'd1000, y, lat);
        check("post_rst_out", longint'(y), 500);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
